pc_sequencer: RTL

- Owns the 16-bit program counter register. Steps it with the 16-bit incrementer (PC+1, modulo 2^16) and feeds fetch addresses to the instruction-memory side over a valid/ready handshake.
- Handles start/halt sequencing and jump redirects, with priority redirect > increment > hold.
- Sits between the control unit (start, halt, redirect) and instruction memory (pc, pc_valid, pc_ready).

---
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the 16-bit PC and issues fetch addresses to instruction memory.
// Latency: all outputs registered; pc_valid rises one cycle after start is sampled, one address per clock.
// Backpressure: pc holds while pc_valid & ~pc_ready; redirect/call/ret may replace an unaccepted pc.
// Optional return-address stack enabled by defining PC_RAS_EN (RAS_DEPTH entries, circular on overflow).
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  input  logic        call,
  input  logic        ret,
  output logic [15:0] pc,
  output logic        pc_valid,
  input  logic        pc_ready,
  output logic        running,
  output logic        wrapped,
  output logic        ras_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] pc_inc;
  logic        wrapped_nxt;
  logic        ras_err_nxt;
  logic        fire;
  logic        do_pop;
  logic        do_push;
  logic        jump;
  logic [15:0] ras_top;

  assign fire   = pc_valid & pc_ready;
  assign pc_inc = pc + 16'd1;

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0]   RAS_FULL_CNT = (PW + 1)'(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE      = PW'(1);
  localparam logic [PW:0]   CNT_ONE      = (PW + 1)'(1);

  logic [15:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_wp;
  logic [PW-1:0] ras_top_idx;
  logic [PW:0]   ras_cnt;
  logic          ras_empty;
  logic          ras_full;

  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == RAS_FULL_CNT);
  assign ras_top_idx = ras_wp - PTR_ONE;
  assign ras_top     = ras_mem[ras_top_idx];

  // ret takes precedence over call; a ret on an empty stack falls through to redirect/fire
  assign do_pop  = ret & ~ras_empty;
  assign do_push = call & ~ret;
  assign jump    = redirect | do_push;

  assign ras_err_nxt = (do_push & ras_full) | (ret & ras_empty);

  // Stack pointer and occupancy; a push when full wraps onto the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_wp  <= '0;
      ras_cnt <= '0;
    end else if (do_pop) begin
      ras_wp  <= ras_wp - PTR_ONE;
      ras_cnt <= ras_cnt - CNT_ONE;
    end else if (do_push) begin
      ras_wp  <= ras_wp + PTR_ONE;
      if (!ras_full) ras_cnt <= ras_cnt + CNT_ONE;
    end
  end

  // Return-address storage; contents are meaningless until pushed, so no reset
  always_ff @(posedge clk) begin
    if (do_push && !do_pop) ras_mem[ras_wp] <= pc_inc;
  end
`else
  logic ras_unused;

  // Without the stack, call is a plain jump and ret has no effect
  assign do_pop      = 1'b0;
  assign do_push     = 1'b0;
  assign jump        = redirect | call;
  assign ras_top     = 16'h0000;
  assign ras_err_nxt = 1'b0;
  assign ras_unused  = ^{ret, do_push, 32'(RAS_DEPTH)};
`endif

  // Next state, next PC (pop > jump > increment > hold) and pulse outputs
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    wrapped_nxt = 1'b0;

    case (state)
      IDLE, HALTED: if (start && !halt) state_nxt = RUN;
      RUN:          if (halt) state_nxt = HALTED;
      default:      state_nxt = IDLE;
    endcase

    if (do_pop) begin
      pc_nxt = ras_top;
    end else if (jump) begin
      pc_nxt = redirect_addr;
    end else if (fire) begin
      pc_nxt      = pc_inc;
      wrapped_nxt = (pc == 16'hFFFF);
    end
  end

  // State and registered outputs; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_VEC;
      pc_valid <= 1'b0;
      running  <= 1'b0;
      wrapped  <= 1'b0;
      ras_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pc_valid <= (state_nxt == RUN);
      running  <= (state_nxt == RUN);
      wrapped  <= wrapped_nxt;
      ras_err  <= ras_err_nxt;
    end
  end

endmodule
